// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: a small FIFO of pending MD ops
// that issues the head whenever the MD unit is idle, plus HI/LO read stall logic.
module md_issue_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        in_ready,
    input  logic        mf_req,
    input  logic        flush,
    output logic        stall,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_busy,
    output logic [3:0]  count,
    output logic        div0
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    r_op_mem [DEPTH];
    logic [31:0]   r_a_mem  [DEPTH];
    logic [31:0]   r_b_mem  [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [3:0]    r_count;
    logic          r_div0;

    logic          w_op_legal;
    logic          w_push;
    logic          w_issue;
    logic [3:0]    w_head_op;
    logic [31:0]   w_head_a;
    logic [31:0]   w_head_b;
    logic          w_div_zero;

    always_comb begin
        w_op_legal = (in_op >= 4'd1) && (in_op <= 4'd6);
        in_ready   = (r_count < 4'(DEPTH));
        w_push     = in_valid & in_ready & w_op_legal & ~flush;
        // reset is also gated here so nothing issues while it is held
        w_issue    = (r_count != '0) & ~md_busy & ~flush & ~reset;
        w_head_op  = r_op_mem[r_rptr];
        w_head_a   = r_a_mem[r_rptr];
        w_head_b   = r_b_mem[r_rptr];
        w_div_zero = w_issue & ((w_head_op == 4'd3) || (w_head_op == 4'd4))
                     & (w_head_b == '0);
    end

    always_comb begin
        md_op = '0;
        md_a  = '0;
        md_b  = '0;
        if (w_issue) begin
            md_op = w_head_op;
            md_a  = w_head_a;
            md_b  = w_head_b;
        end
    end

    assign stall = (in_valid & ~in_ready) | (mf_req & ((r_count != '0) | md_busy));
    assign count = r_count;
    assign div0  = r_div0;

    // storage is not reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wptr] <= in_op;
            r_a_mem[r_wptr]  <= in_a;
            r_b_mem[r_wptr]  <= in_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_div0  <= 1'b0;
        end else begin
            if (w_div_zero) begin
                r_div0 <= 1'b1;
            end
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_issue) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                r_count <= r_count + {3'b000, w_push} - {3'b000, w_issue};
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: expected issues are queued at push time and
// checked by a monitor; a simple MD-unit model raises md_busy after long ops.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ready;
    logic        mf_req;
    logic        flush;
    logic        stall;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic [3:0]  count;
    logic        div0;

    logic        busy_force = 1'b0;
    logic        model_busy = 1'b0;
    logic        long_seen  = 1'b0;
    int          busy_left  = 0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t sb[$];

    assign md_busy = busy_force | model_busy;

    md_issue_ctrl #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .mf_req(mf_req),
        .flush(flush), .stall(stall), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .md_busy(md_busy), .count(count), .div0(div0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every nonzero md_op must match the oldest expected issue
    always @(negedge clk) begin
        long_seen = (md_op >= 4'd1) && (md_op <= 4'd4);
        if (md_op != 4'd0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got op %0h expected none", md_op);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_op", {28'd0, md_op}, {28'd0, e.op});
                check("issue_a", md_a, e.a);
                check("issue_b", md_b, e.b);
            end
        end
    end

    // MD-unit model: busy for three cycles after each MULT/MULTU/DIV/DIVU issue
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_left != 0) busy_left--;
            if (long_seen) busy_left = 3;
            model_busy = (busy_left != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic expect_issue);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        if (expect_issue) sb.push_back('{op: op, a: a, b: b});
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        mf_req = 1'b0;
        flush = 1'b0;
        idle();
        #1;
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_md_op", {28'd0, md_op}, 32'd0);
        check("rst_div0", {31'd0, div0}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // single MULT, minimum latency
        drive(1'b1, 4'd1, 32'd3, 32'd5, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("mult_latency_op", {28'd0, md_op}, 32'd1);
        check("mult_count_during", {28'd0, count}, 32'd1);
        tick();
        @(negedge clk);
        check("mult_count_after", {28'd0, count}, 32'd0);
        check("busy_after_mult", {31'd0, md_busy}, 32'd1);
        ticks(5);

        // queue fills while busy; third op rejected
        busy_force = 1'b1;
        drive(1'b1, 4'd2, 32'd1, 32'd2, 1'b1);
        tick();
        drive(1'b1, 4'd3, 32'd20, 32'd4, 1'b1);
        tick();
        drive(1'b1, 4'd4, 32'd30, 32'd6, 1'b0);
        @(negedge clk);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        check("full_stall", {31'd0, stall}, 32'd1);
        check("full_count", {28'd0, count}, 32'd2);
        tick();
        idle();
        busy_force = 1'b0;
        @(negedge clk);
        check("drain_first", {28'd0, md_op}, 32'd2);
        ticks(12);
        @(negedge clk);
        check("drain_count", {28'd0, count}, 32'd0);
        tick();

        // MTLO, MTHI, MULT back to back
        drive(1'b1, 4'd5, 32'd7, 32'd0, 1'b1);
        tick();
        drive(1'b1, 4'd6, 32'd9, 32'd0, 1'b1);
        @(negedge clk);
        check("b2b_mtlo", {28'd0, md_op}, 32'd5);
        tick();
        drive(1'b1, 4'd1, 32'd2, 32'd2, 1'b1);
        @(negedge clk);
        check("b2b_mthi", {28'd0, md_op}, 32'd6);
        tick();
        drive(1'b1, 4'd0, 32'd11, 32'd11, 1'b0);
        @(negedge clk);
        check("b2b_mult", {28'd0, md_op}, 32'd1);
        check("bad_op_nostall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 4'd9, 32'd12, 32'd12, 1'b0);
        tick();
        idle();
        @(negedge clk);
        check("bad_op_dropped", {28'd0, count}, 32'd0);
        ticks(5);

        // mf_req stall
        busy_force = 1'b1;
        drive(1'b1, 4'd1, 32'd4, 32'd4, 1'b1);
        tick();
        idle();
        mf_req = 1'b1;
        @(negedge clk);
        check("mf_stall_pending", {31'd0, stall}, 32'd1);
        tick();
        busy_force = 1'b0;
        ticks(6);
        @(negedge clk);
        check("mf_nostall_idle", {31'd0, stall}, 32'd0);
        tick();
        mf_req = 1'b0;

        // divide by zero, then flush with a same-cycle push
        drive(1'b1, 4'd3, 32'd10, 32'd0, 1'b1);
        tick();
        idle();
        tick();
        @(negedge clk);
        check("div0_set", {31'd0, div0}, 32'd1);
        ticks(5);
        busy_force = 1'b1;
        drive(1'b1, 4'd5, 32'd1, 32'd0, 1'b0);
        tick();
        drive(1'b1, 4'd6, 32'd2, 32'd0, 1'b0);
        tick();
        busy_force = 1'b0;
        flush = 1'b1;
        drive(1'b1, 4'd5, 32'd3, 32'd0, 1'b0);
        @(negedge clk);
        check("flush_no_issue", {28'd0, md_op}, 32'd0);
        tick();
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_count", {28'd0, count}, 32'd0);
        check("div0_sticky", {31'd0, div0}, 32'd1);
        ticks(3);

        // asynchronous reset between edges with a full queue
        busy_force = 1'b1;
        drive(1'b1, 4'd1, 32'd1, 32'd1, 1'b0);
        tick();
        drive(1'b1, 4'd1, 32'd2, 32'd2, 1'b0);
        tick();
        idle();
        mf_req = 1'b1;
        #1;
        check("pre_reset_count", {28'd0, count}, 32'd2);
        reset = 1'b1;
        #1;
        check("async_count", {28'd0, count}, 32'd0);
        check("async_md_op", {28'd0, md_op}, 32'd0);
        check("async_ready", {31'd0, in_ready}, 32'd1);
        check("async_div0", {31'd0, div0}, 32'd0);
        check("async_stall_busy", {31'd0, stall}, 32'd1);
        busy_force = 1'b0;
        #1;
        check("async_stall_idle", {31'd0, stall}, 32'd0);
        check("async_md_op_idle", {28'd0, md_op}, 32'd0);
        tick();
        reset = 1'b0;
        mf_req = 1'b0;
        ticks(3);
        @(negedge clk);
        check("post_reset_count", {28'd0, count}, 32'd0);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the pending-op queue depth (power of two, 2..8).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  pipeline presents an MD op this cycle.
REQ-005 The block SHALL have port in_op  input  4  op code: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTLO, 6 MTHI.
REQ-006 The block SHALL have port in_a  input  32  first operand (rs).
REQ-007 The block SHALL have port in_b  input  32  second operand (rt).
REQ-008 The block SHALL have port in_ready  output  1  queue can accept an op this cycle.
REQ-009 The block SHALL have port mf_req  input  1  pipeline wants to read HI or LO this cycle.
REQ-010 The block SHALL have port flush  input  1  discards all queued, not-yet-issued ops.
REQ-011 The block SHALL have port stall  output  1  pipeline must hold its E stage.
REQ-012 The block SHALL have port md_op  output  4  op driven to the MD unit; 0 = no op.
REQ-013 The block SHALL have port md_a  output  32  operand A to the MD unit.
REQ-014 The block SHALL have port md_b  output  32  operand B to the MD unit.
REQ-015 The block SHALL have port md_busy  input  1  MD unit busy; rises the cycle after a MULT/MULTU/DIV/DIVU is issued.
REQ-016 The block SHALL have port count  output  4  number of queued ops, 0..DEPTH.
REQ-017 The block SHALL have port div0  output  1  sticky flag: a DIV/DIVU with zero divisor was issued.

Function
REQ-018 Queue is FIFO with read/write pointers wrapping modulo DEPTH; order of ops is preserved.
REQ-019 in_ready SHALL be 1 exactly when count < DEPTH; a pop in the same cycle does not raise in_ready (no bypass).
REQ-020 Push at the edge when in_valid & in_ready & in_op in 1..6 & !flush; in_op 0 or 7..15 is dropped silently, no stall.
REQ-021 Issue condition: count != 0 & !md_busy & !flush; when true, md_op/md_a/md_b SHALL combinationally equal the queue head and the head is popped at that edge.
REQ-022 When the issue condition is false, md_op, md_a and md_b SHALL be 0.
REQ-023 Minimum latency accept-to-issue is 1 cycle: op accepted at edge N appears on md_op in cycle N+1 if md_busy is low.
REQ-024 MTLO/MTHI do not raise md_busy; consecutive MTLO/MTHI/first-MULT ops SHALL issue in back-to-back cycles.
REQ-025 After a MULT/MULTU/DIV/DIVU issue, no further issue occurs until md_busy returns to 0.
REQ-026 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 flush: count and pointers set to 0 at the edge, no issue that cycle, same-cycle push discarded; an op already in the MD unit is unaffected.
REQ-028 stall SHALL equal (in_valid & !in_ready) | (mf_req & (count != 0 | md_busy)).
REQ-029 div0 SHALL set at the edge an op 3 or 4 issues with md_b == 0; cleared only by reset.
REQ-030 count SHALL reflect registered occupancy (value after the last edge).

Reset
REQ-031 On reset assertion, immediately and without a clock: count=0, pointers=0, div0=0; consequently md_op=0, md_a=0, md_b=0, in_ready=1, stall = mf_req & md_busy.
REQ-032 Reset mid-operation SHALL discard all queued ops; no op is issued while reset is high.
REQ-033 Queue storage contents need not be reset.

Verification
REQ-034 Push MULT a=3 b=5, md_busy low -> next cycle md_op=1, md_a=3, md_b=5; count returns to 0.
REQ-035 md_busy held high, push 3 ops with DEPTH=2 -> third cycle in_ready=0, stall=1, count=2; release busy -> ops issue in order, one per free cycle.
REQ-036 Push MTLO a=7 then MTHI a=9 back-to-back, busy low -> md_op=5 then 6 in consecutive cycles.
REQ-037 mf_req=1 with count=1 -> stall=1; with count=0 and md_busy=0 -> stall=0.
REQ-038 Issue DIV a=10 b=0 -> div0=1 persists until reset; flush with count=2 plus same-cycle push -> count=0, md_op=0.
REQ-039 Assert reset asynchronously between edges with count=2 -> count=0, md_op=0 before next edge.
